exception_ctrl: RTL and testbench
=================================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 The block SHALL have parameter EXC_VECTOR, default 32'hBFC00380, the handler entry address.
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 1, the flush pulse length in cycles (legal range 1..15).
REQ-003 Reset: rst, synchronous, active-high; clock: clk.
REQ-004 clk  in  1  clock, rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 stall_i  in  1  memory stage stalled; no exception is accepted while high.
REQ-007 valid_i  in  1  memory-stage instruction is valid (not a bubble).
REQ-008 inst_addr_i  in  32  PC of the memory-stage instruction.
REQ-009 in_delayslot_i  in  1  instruction sits in a branch delay slot.
REQ-010 data_addr_i  in  32  load/store effective address.
REQ-011 exc_flags_i  in  9  raw flags [0]AdEL-fetch [1]RI [2]Ov [3]Trap [4]Syscall [5]Break [6]Eret [7]AdEL-load [8]AdES.
REQ-012 status_i, cause_i, epc_i  in  32 each  current CP0 Status/Cause/EPC.
REQ-013 cp0_we_i  in  1; cp0_waddr_i  in  5; cp0_wdata_i  in  32  CP0 write in flight (writeback), for forwarding.
REQ-014 excepttype_o  out  32  exception code to CP0 (0 = none).
REQ-015 exc_pc_o  out  32; exc_delayslot_o  out  1; bad_addr_o  out  32  context to CP0.
REQ-016 flush_o  out  1  pipeline flush; newpc_o  out  32  redirect target, valid while flush_o=1.
REQ-017 busy_o  out  1  high while in FLUSH state.

Function
REQ-018 Forwarded Status/Cause/EPC SHALL be cp0_wdata_i when cp0_we_i=1 and cp0_waddr_i equals 12/13/14 respectively, else status_i/cause_i/epc_i; for Cause only bits [9:8] are forwarded.
REQ-019 Interrupt pending SHALL be ((Cause[15:8] & Status[15:8]) != 0) && Status[0]==1 && Status[1]==0, using forwarded values.
REQ-020 Detection SHALL be qualified by valid_i=1, stall_i=0 and state IDLE; otherwise no exception is detected.
REQ-021 Priority (highest first) with code: interrupt 0x01, AdEL-fetch 0x04, RI 0x0a, Ov 0x0c, Trap 0x0d, Syscall 0x08, Break 0x09, Eret 0x0e, AdEL-load 0x04, AdES 0x05.
REQ-022 On detection, at the next rising edge the block SHALL register excepttype_o=code, exc_pc_o=inst_addr_i, exc_delayslot_o=in_delayslot_i, and enter FLUSH.
REQ-023 bad_addr_o SHALL be inst_addr_i for AdEL-fetch, data_addr_i for AdEL-load/AdES, otherwise hold its previous value.
REQ-024 newpc_o SHALL be forwarded EPC for Eret, EXC_VECTOR for all other codes, captured at detection.
REQ-025 excepttype_o SHALL be nonzero for exactly the first FLUSH cycle, then return to 0, so CP0 sees one event per exception.
REQ-026 States: IDLE -> FLUSH on detection; FLUSH with counter loaded FLUSH_CYCLES-1, decrements each cycle, FLUSH -> IDLE when counter is 0.
REQ-027 flush_o and busy_o SHALL be 1 in every FLUSH cycle (exactly FLUSH_CYCLES cycles), 0 in IDLE.
REQ-028 Exceptions presented during FLUSH SHALL be discarded (flushed instructions), not queued.
REQ-029 stall_i during FLUSH SHALL NOT extend or pause the flush counter.

Reset
REQ-030 rst=1 SHALL force state IDLE, counter 0, excepttype_o=0, exc_pc_o=0, exc_delayslot_o=0, bad_addr_o=0, flush_o=0, newpc_o=0, busy_o=0 at the next edge, including mid-FLUSH.

Verification
REQ-031 Syscall at PC 0xBFC00100, not in slot -> next edge excepttype_o=0x08, exc_pc_o=0xBFC00100, flush_o=1 one cycle, newpc_o=0xBFC00380.
REQ-032 Flags AdES+Ov, data_addr 0x80000003 -> excepttype_o=0x0c, bad_addr_o unchanged.
REQ-033 Status=0x00000401, Cause[10]=1, Break flag set -> excepttype_o=0x01; same with Status[1]=1 -> 0x09.
REQ-034 Eret, epc_i=0x100, cp0 write EPC=0x200 same cycle -> excepttype_o=0x0e, newpc_o=0x200.
REQ-035 FLUSH_CYCLES=3: Trap then RI on following cycles -> flush_o high 3 cycles, excepttype_o=0x0d one cycle, RI ignored.
REQ-036 rst asserted in 2nd FLUSH cycle -> next edge all outputs 0, IDLE; stall_i=1 with Syscall -> no response.

Source files
------------

// File: rtl/exception_ctrl.sv
// Exception controller for the memory stage.
// Prioritises interrupts and synchronous exceptions, forwards in-flight CP0
// writes, and reports one event per exception to CP0. On each exception it
// raises a pipeline flush that lasts FLUSH_CYCLES cycles, with a redirect PC.
module exception_ctrl #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        valid_i,
   input  logic [31:0] inst_addr_i,
   input  logic        in_delayslot_i,
   input  logic [31:0] data_addr_i,
   input  logic [8:0]  exc_flags_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   input  logic        cp0_we_i,
   input  logic [4:0]  cp0_waddr_i,
   input  logic [31:0] cp0_wdata_i,
   output logic [31:0] excepttype_o,
   output logic [31:0] exc_pc_o,
   output logic        exc_delayslot_o,
   output logic [31:0] bad_addr_o,
   output logic        flush_o,
   output logic [31:0] newpc_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1
   } state_e;

   localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

   state_e      state_q;
   logic [3:0]  cnt_q;

   logic [15:0] status_fwd;
   logic [7:0]  cause_ip;
   logic [31:0] epc_fwd;
   logic        int_pending;
   logic [4:0]  code;
   logic        bad_from_inst;
   logic        bad_from_data;
   logic        is_eret;
   logic        detect;

   // Only the Status/Cause bits that matter for interrupts are consumed.
   logic unused_bits;
   assign unused_bits = ^{status_i[31:16], cause_i[31:16], cause_i[7:0]};

   // Forward an in-flight CP0 write; for Cause only the software IP bits are writable.
   always_comb begin
      status_fwd = status_i[15:0];
      cause_ip   = cause_i[15:8];
      epc_fwd    = epc_i;
      if (cp0_we_i && (cp0_waddr_i == 5'd12)) begin
         status_fwd = cp0_wdata_i[15:0];
      end else begin
         status_fwd = status_i[15:0];
      end
      if (cp0_we_i && (cp0_waddr_i == 5'd13)) begin
         cause_ip = {cause_i[15:10], cp0_wdata_i[9:8]};
      end else begin
         cause_ip = cause_i[15:8];
      end
      if (cp0_we_i && (cp0_waddr_i == 5'd14)) begin
         epc_fwd = cp0_wdata_i;
      end else begin
         epc_fwd = epc_i;
      end
   end

   assign int_pending = ((cause_ip & status_fwd[15:8]) != 8'h00) &&
                        status_fwd[0] && !status_fwd[1];

   // Pick the highest-priority exception of a qualified instruction.
   always_comb begin
      code          = 5'h00;
      bad_from_inst = 1'b0;
      bad_from_data = 1'b0;
      is_eret       = 1'b0;
      if (!valid_i || stall_i || (state_q != IDLE)) begin
         code = 5'h00;
      end else if (int_pending) begin
         code = 5'h01;
      end else if (exc_flags_i[0]) begin
         code          = 5'h04;
         bad_from_inst = 1'b1;
      end else if (exc_flags_i[1]) begin
         code = 5'h0a;
      end else if (exc_flags_i[2]) begin
         code = 5'h0c;
      end else if (exc_flags_i[3]) begin
         code = 5'h0d;
      end else if (exc_flags_i[4]) begin
         code = 5'h08;
      end else if (exc_flags_i[5]) begin
         code = 5'h09;
      end else if (exc_flags_i[6]) begin
         code    = 5'h0e;
         is_eret = 1'b1;
      end else if (exc_flags_i[7]) begin
         code          = 5'h04;
         bad_from_data = 1'b1;
      end else if (exc_flags_i[8]) begin
         code          = 5'h05;
         bad_from_data = 1'b1;
      end else begin
         code = 5'h00;
      end
   end

   assign detect = (code != 5'h00);

   // Flush FSM and registered CP0 context / redirect outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         cnt_q           <= 4'd0;
         excepttype_o    <= 32'h0;
         exc_pc_o        <= 32'h0;
         exc_delayslot_o <= 1'b0;
         bad_addr_o      <= 32'h0;
         flush_o         <= 1'b0;
         newpc_o         <= 32'h0;
         busy_o          <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (detect) begin
                  state_q         <= FLUSH;
                  cnt_q           <= CNT_LOAD;
                  excepttype_o    <= {27'h0, code};
                  exc_pc_o        <= inst_addr_i;
                  exc_delayslot_o <= in_delayslot_i;
                  flush_o         <= 1'b1;
                  busy_o          <= 1'b1;
                  newpc_o         <= is_eret ? epc_fwd : EXC_VECTOR;
                  if (bad_from_inst) begin
                     bad_addr_o <= inst_addr_i;
                  end else if (bad_from_data) begin
                     bad_addr_o <= data_addr_i;
                  end else begin
                     bad_addr_o <= bad_addr_o;
                  end
               end else begin
                  excepttype_o <= 32'h0;
                  flush_o      <= 1'b0;
                  busy_o       <= 1'b0;
               end
            end
            FLUSH: begin
               // One CP0 event per exception; later flags belong to flushed work.
               excepttype_o <= 32'h0;
               if (cnt_q == 4'd0) begin
                  state_q <= IDLE;
                  flush_o <= 1'b0;
                  busy_o  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q      <= IDLE;
               cnt_q        <= 4'd0;
               excepttype_o <= 32'h0;
               flush_o      <= 1'b0;
               busy_o       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: one instance with a single-cycle
// flush and one with a three-cycle flush, both fed the same stimulus.
// Expected outputs are queued when stimulus is driven and compared after the edge.
module tb_exception_ctrl;

   typedef struct packed {
      logic [31:0] et;
      logic [31:0] pc;
      logic        ds;
      logic [31:0] bad;
      logic        fl;
      logic [31:0] np;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        valid_i;
   logic [31:0] inst_addr_i;
   logic        in_delayslot_i;
   logic [31:0] data_addr_i;
   logic [8:0]  exc_flags_i;
   logic [31:0] status_i;
   logic [31:0] cause_i;
   logic [31:0] epc_i;
   logic        cp0_we_i;
   logic [4:0]  cp0_waddr_i;
   logic [31:0] cp0_wdata_i;

   logic [31:0] d1_et, d1_pc, d1_bad, d1_np;
   logic        d1_ds, d1_fl, d1_busy;
   logic [31:0] d3_et, d3_pc, d3_bad, d3_np;
   logic        d3_ds, d3_fl, d3_busy;

   int n_checks = 0;
   int n_pass   = 0;

   exp_t q1[$];
   exp_t q3[$];

   exception_ctrl #(.EXC_VECTOR(32'hBFC00380), .FLUSH_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .stall_i(stall_i), .valid_i(valid_i),
      .inst_addr_i(inst_addr_i), .in_delayslot_i(in_delayslot_i),
      .data_addr_i(data_addr_i), .exc_flags_i(exc_flags_i),
      .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
      .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
      .excepttype_o(d1_et), .exc_pc_o(d1_pc), .exc_delayslot_o(d1_ds),
      .bad_addr_o(d1_bad), .flush_o(d1_fl), .newpc_o(d1_np), .busy_o(d1_busy)
   );

   exception_ctrl #(.EXC_VECTOR(32'hBFC00380), .FLUSH_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst), .stall_i(stall_i), .valid_i(valid_i),
      .inst_addr_i(inst_addr_i), .in_delayslot_i(in_delayslot_i),
      .data_addr_i(data_addr_i), .exc_flags_i(exc_flags_i),
      .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
      .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
      .excepttype_o(d3_et), .exc_pc_o(d3_pc), .exc_delayslot_o(d3_ds),
      .bad_addr_o(d3_bad), .flush_o(d3_fl), .newpc_o(d3_np), .busy_o(d3_busy)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   function automatic exp_t mk(logic [31:0] et, logic [31:0] pc, logic ds,
                               logic [31:0] bad, logic fl, logic [31:0] np);
      exp_t e;
      e.et = et; e.pc = pc; e.ds = ds; e.bad = bad; e.fl = fl; e.np = np;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %08h, expected %08h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      stall_i = 1'b0; valid_i = 1'b1; inst_addr_i = 32'h0; in_delayslot_i = 1'b0;
      data_addr_i = 32'h0; exc_flags_i = 9'h000; status_i = 32'h0; cause_i = 32'h0;
      epc_i = 32'h0; cp0_we_i = 1'b0; cp0_waddr_i = 5'd0; cp0_wdata_i = 32'h0;
   endtask

   // Queue expectations for the coming edge, then pop and compare after it.
   task automatic step(input string tag, input exp_t e1, input bit c3, input exp_t e3);
      exp_t x;
      q1.push_back(e1);
      if (c3) q3.push_back(e3);
      @(posedge clk);
      #1;
      x = q1.pop_front();
      check({tag, "/d1.excepttype"}, d1_et, x.et);
      check({tag, "/d1.exc_pc"}, d1_pc, x.pc);
      check({tag, "/d1.delayslot"}, {31'h0, d1_ds}, {31'h0, x.ds});
      check({tag, "/d1.bad_addr"}, d1_bad, x.bad);
      check({tag, "/d1.flush"}, {31'h0, d1_fl}, {31'h0, x.fl});
      check({tag, "/d1.busy"}, {31'h0, d1_busy}, {31'h0, x.fl});
      check({tag, "/d1.newpc"}, d1_np, x.np);
      if (q3.size() != 0) begin
         x = q3.pop_front();
         check({tag, "/d3.excepttype"}, d3_et, x.et);
         check({tag, "/d3.exc_pc"}, d3_pc, x.pc);
         check({tag, "/d3.delayslot"}, {31'h0, d3_ds}, {31'h0, x.ds});
         check({tag, "/d3.bad_addr"}, d3_bad, x.bad);
         check({tag, "/d3.flush"}, {31'h0, d3_fl}, {31'h0, x.fl});
         check({tag, "/d3.busy"}, {31'h0, d3_busy}, {31'h0, x.fl});
         check({tag, "/d3.newpc"}, d3_np, x.np);
      end
   endtask

   localparam logic [31:0] VEC = 32'hBFC00380;

   initial begin
      exp_t z;
      z = mk(32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      clk = 1'b0;
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);

      // Reset state
      step("reset", z, 1'b1, z);
      rst = 1'b0;

      // Syscall, not in slot
      inst_addr_i = 32'hBFC00100; exc_flags_i = 9'h010;
      step("sys", mk(32'h08, 32'hBFC00100, 1'b0, 32'h0, 1'b1, VEC), 1'b0, z);
      idle_inputs();
      step("sys_end", mk(32'h0, 32'hBFC00100, 1'b0, 32'h0, 1'b0, VEC), 1'b0, z);

      // AdEL-fetch in delay slot: bad address is the PC
      inst_addr_i = 32'h80001000; in_delayslot_i = 1'b1; exc_flags_i = 9'h001;
      step("adel_f", mk(32'h04, 32'h80001000, 1'b1, 32'h80001000, 1'b1, VEC), 1'b0, z);
      idle_inputs();
      step("adel_f_end", mk(32'h0, 32'h80001000, 1'b1, 32'h80001000, 1'b0, VEC), 1'b0, z);

      // AdES + Ov: overflow wins, bad address unchanged
      inst_addr_i = 32'h80002000; data_addr_i = 32'h80000003; exc_flags_i = 9'h104;
      step("ov_ades", mk(32'h0c, 32'h80002000, 1'b0, 32'h80001000, 1'b1, VEC), 1'b0, z);
      idle_inputs();
      step("ov_end", mk(32'h0, 32'h80002000, 1'b0, 32'h80001000, 1'b0, VEC), 1'b0, z);

      // AdEL-load: bad address is the data address
      inst_addr_i = 32'h80002004; data_addr_i = 32'h80000005; exc_flags_i = 9'h080;
      step("adel_l", mk(32'h04, 32'h80002004, 1'b0, 32'h80000005, 1'b1, VEC), 1'b0, z);
      idle_inputs();
      step("adel_l_end", mk(32'h0, 32'h80002004, 1'b0, 32'h80000005, 1'b0, VEC), 1'b0, z);

      // Interrupt beats Break; masked by EXL gives Break
      inst_addr_i = 32'h80003000; status_i = 32'h00000401; cause_i = 32'h00000400;
      exc_flags_i = 9'h020;
      step("int", mk(32'h01, 32'h80003000, 1'b0, 32'h80000005, 1'b1, VEC), 1'b0, z);
      idle_inputs();
      step("int_end", mk(32'h0, 32'h80003000, 1'b0, 32'h80000005, 1'b0, VEC), 1'b0, z);
      inst_addr_i = 32'h80003004; status_i = 32'h00000403; cause_i = 32'h00000400;
      exc_flags_i = 9'h020;
      step("brk_exl", mk(32'h09, 32'h80003004, 1'b0, 32'h80000005, 1'b1, VEC), 1'b0, z);
      idle_inputs();
      step("brk_end", mk(32'h0, 32'h80003004, 1'b0, 32'h80000005, 1'b0, VEC), 1'b0, z);

      // Forwarded Cause software IP bit raises an interrupt
      inst_addr_i = 32'h80003100; status_i = 32'h00000101;
      cp0_we_i = 1'b1; cp0_waddr_i = 5'd13; cp0_wdata_i = 32'h00000100;
      step("fwd_ip", mk(32'h01, 32'h80003100, 1'b0, 32'h80000005, 1'b1, VEC), 1'b0, z);
      idle_inputs();
      step("fwd_ip_end", mk(32'h0, 32'h80003100, 1'b0, 32'h80000005, 1'b0, VEC), 1'b0, z);

      // Cause hardware IP bits are not forwarded
      inst_addr_i = 32'h80003200; status_i = 32'h00000401;
      cp0_we_i = 1'b1; cp0_waddr_i = 5'd13; cp0_wdata_i = 32'h00000400;
      step("fwd_hw", mk(32'h0, 32'h80003100, 1'b0, 32'h80000005, 1'b0, VEC), 1'b0, z);

      // Eret with forwarded EPC
      idle_inputs();
      inst_addr_i = 32'h80003300; exc_flags_i = 9'h040; epc_i = 32'h00000100;
      cp0_we_i = 1'b1; cp0_waddr_i = 5'd14; cp0_wdata_i = 32'h00000200;
      step("eret", mk(32'h0e, 32'h80003300, 1'b0, 32'h80000005, 1'b1, 32'h200), 1'b0, z);
      idle_inputs();
      step("eret_end", mk(32'h0, 32'h80003300, 1'b0, 32'h80000005, 1'b0, 32'h200), 1'b0, z);

      // Bubble and stalled instruction are ignored
      inst_addr_i = 32'h80003400; exc_flags_i = 9'h010; valid_i = 1'b0;
      step("bubble", mk(32'h0, 32'h80003300, 1'b0, 32'h80000005, 1'b0, 32'h200), 1'b0, z);
      valid_i = 1'b1; stall_i = 1'b1;
      step("stall", mk(32'h0, 32'h80003300, 1'b0, 32'h80000005, 1'b0, 32'h200), 1'b0, z);

      // Three-cycle flush: Trap then RI; stall inside flush does not pause it
      idle_inputs();
      rst = 1'b1;
      step("rst2", z, 1'b1, z);
      rst = 1'b0;
      inst_addr_i = 32'h80004000; exc_flags_i = 9'h008;
      step("trap", mk(32'h0d, 32'h80004000, 1'b0, 32'h0, 1'b1, VEC), 1'b1,
           mk(32'h0d, 32'h80004000, 1'b0, 32'h0, 1'b1, VEC));
      inst_addr_i = 32'h80004004; exc_flags_i = 9'h002; stall_i = 1'b1;
      step("trap_c2", mk(32'h0, 32'h80004000, 1'b0, 32'h0, 1'b0, VEC), 1'b1,
           mk(32'h0, 32'h80004000, 1'b0, 32'h0, 1'b1, VEC));
      inst_addr_i = 32'h80004008; stall_i = 1'b0;
      step("trap_c3", mk(32'h0a, 32'h80004008, 1'b0, 32'h0, 1'b1, VEC), 1'b1,
           mk(32'h0, 32'h80004000, 1'b0, 32'h0, 1'b1, VEC));
      idle_inputs();
      step("trap_end", mk(32'h0, 32'h80004008, 1'b0, 32'h0, 1'b0, VEC), 1'b1,
           mk(32'h0, 32'h80004000, 1'b0, 32'h0, 1'b0, VEC));

      // Reset during the second flush cycle
      inst_addr_i = 32'h80005000; exc_flags_i = 9'h008;
      step("trap2", mk(32'h0d, 32'h80005000, 1'b0, 32'h0, 1'b1, VEC), 1'b1,
           mk(32'h0d, 32'h80005000, 1'b0, 32'h0, 1'b1, VEC));
      idle_inputs();
      step("trap2_c2", mk(32'h0, 32'h80005000, 1'b0, 32'h0, 1'b0, VEC), 1'b1,
           mk(32'h0, 32'h80005000, 1'b0, 32'h0, 1'b1, VEC));
      rst = 1'b1;
      step("rst_mid", z, 1'b1, z);
      rst = 1'b0;
      step("post_rst", z, 1'b1, z);
      inst_addr_i = 32'h80006000; exc_flags_i = 9'h010;
      step("sys_again", mk(32'h08, 32'h80006000, 1'b0, 32'h0, 1'b1, VEC), 1'b1,
           mk(32'h08, 32'h80006000, 1'b0, 32'h0, 1'b1, VEC));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
